// File: rtl/serial_adder4.sv
// serial_adder4: bit-serial WIDTH-bit adder built from one full-adder slice.
// The slice is two cascaded half-adders plus a carry flop, processing one
// operand bit per clock, LSB first, with a start/busy/done handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only in IDLE or DONE
//   sub    in   (SERIAL_ADD_SUB_EN builds only) subtract A-B, captured on start
//   A, B   in   operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   busy   out  high while the slice is shifting
//   done   out  one-cycle pulse when sum/carry update
//   sum    out  registered result, held until the next completion
//   carry  out  registered carry-out (no-borrow flag when subtracting)
//
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub input.

module serial_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] res;
    logic             cflop;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             shift;
    logic             finish;
    logic             last;

    logic [WIDTH-1:0] b_in;
    logic             c_in;

    logic             a;
    logic             b;
    logic             s1;
    logic             c1;
    logic             s;
    logic             c2;
    logic             cout;

    // Operand conditioning at capture time. Subtraction is A + ~B + 1,
    // so B is inverted on the way in and the carry flop is preset.
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_in = B;
        c_in = cin;
        if (sub) begin
            b_in = ~B;
            c_in = 1'b1;
        end
    end
`else
    always_comb begin
        b_in = B;
        c_in = cin;
    end
`endif

    // Full-adder slice as two cascaded half-adders.
    always_comb begin
        a    = areg[0];
        b    = breg[0];
        s1   = a ^ b;
        c1   = a & b;
        s    = s1 ^ cflop;
        c2   = s1 & cflop;
        cout = c1 | c2;
    end

    assign last = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Operand shift registers, carry flop, bit counter and result shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg  <= '0;
            breg  <= '0;
            res   <= '0;
            cflop <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            areg  <= A;
            breg  <= b_in;
            res   <= '0;
            cflop <= c_in;
            cnt   <= '0;
        end else if (shift) begin
            areg  <= areg >> 1;
            breg  <= breg >> 1;
            res   <= {s, res[WIDTH-1:1]};
            cflop <= cout;
            cnt   <= cnt + CW'(1);
        end
    end

    // Visible result: the final bit is folded in directly so sum/carry
    // update on the same edge that enters DONE and never show partials.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (finish) begin
            sum   <= {s, res[WIDTH-1:1]};
            carry <= cout;
        end
    end

endmodule

// File: tb/tb_serial_adder4.sv
// tb_serial_adder4: directed and random checks of serial_adder4 (WIDTH=4)
// against an arithmetic reference model.

module tb_serial_adder4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic         sub_v = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_adder4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub_v),
`endif
        .A     (A),
        .B     (B),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {carry, sum} from plain arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic ci,
                                         input logic sb);
        int unsigned r;
        logic [W:0] t;
        if (sb) begin
            r = (int'(a) - int'(b) + (1 << W)) % (1 << W);
            t = {(a >= b), r[W-1:0]};
        end else begin
            r = int'(a) + int'(b) + int'(ci);
            t = r[W:0];
        end
        return t;
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci,
                          input logic sb);
        logic [W:0]   e;
        logic [W-1:0] hs;
        logic         hc;
        int           k;
        int           nb;
        bit           got;
        bit           stable;
        e = model(a, b, ci, sb);
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        cin = ci;
        sub_v = sb;
        hs = sum;
        hc = carry;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        nb = 0;
        got = 1'b0;
        stable = 1'b1;
        while (k < 20 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) nb++;
                if (sum !== hs || carry !== hc) stable = 1'b0;
                k++;
                @(negedge clk);
            end
        end
        chk({tag, "_done"}, 32'(got), 1);
        chk({tag, "_lat"}, k, W);
        chk({tag, "_busy"}, nb, W);
        chk({tag, "_hold"}, 32'(stable), 1);
        chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
        chk({tag, "_carry"}, 32'(carry), 32'(e[W]));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 0);
    endtask

    initial begin : main
        int k;
        int nd;
        int dt[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        logic rs;

        #1 rst = 1'b1;
        #6;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_carry", 32'(carry), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 4'h5, 4'h3, 1'b0, 1'b0);
        run_op("wrap", 4'hF, 4'h1, 1'b0, 1'b0);
        run_op("cin", 4'hF, 4'hF, 1'b1, 1'b0);

        // start pulse while shifting must be ignored
        @(negedge clk);
        start = 1'b1; A = 4'h2; B = 4'h2; cin = 1'b0; sub_v = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 4'h7; B = 4'h7;
        @(negedge clk);
        start = 1'b0;
        k = 2;
        while (k < 20 && !done) begin
            k++;
            @(negedge clk);
        end
        chk("ign_lat", k, W);
        chk("ign_sum", 32'(sum), 4);
        chk("ign_carry", 32'(carry), 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("ign_nodone", nd, 0);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1; A = 4'h1; B = 4'h1; cin = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) begin
                dt.push_back(c);
                if (dt.size() == 1) begin
                    chk("b2b_sum0", 32'(sum), 2);
                    chk("b2b_carry0", 32'(carry), 0);
                    A = 4'h6;
                    B = 4'h9;
                end else if (dt.size() == 2) begin
                    chk("b2b_sum1", 32'(sum), 4'hF);
                    chk("b2b_carry1", 32'(carry), 0);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", dt.size(), 2);
        if (dt.size() >= 2) begin
            chk("b2b_first", dt[0], W);
            chk("b2b_gap", dt[1] - dt[0], W + 1);
        end

        // reset in the middle of shifting
        @(negedge clk);
        start = 1'b1; A = 4'h5; B = 4'h6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_sum", 32'(sum), 0);
        chk("mid_carry", 32'(carry), 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_nodone", nd, 0);
        run_op("after_rst", 4'h4, 4'h4, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_borrow", 4'h3, 4'h5, 1'b0, 1'b1);
        run_op("sub_ok", 4'h9, 4'h4, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`endif
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
